dds_sweep: RTL and testbench
============================

# dds_sweep

Frequency-sweep controller placed directly upstream of the DDS sine generator. It drives the DDS 16-bit `freq` input with a staircase of frequency words from a start value to a stop value. Each step is held for a programmable number of clock cycles. Single-shot, sawtooth-repeat and triangle-repeat modes are supported, with a start/abort/busy/done control handshake for the host.

## Interface
Parameters:
- `W`, 16: frequency word width; matches the DDS `freq` port.
- `DW`, 16: dwell counter width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; latches configuration and begins a sweep when idle.
- `abort`  in  1  pulse; stops the sweep and returns to idle.
- `mode`  in  2  0 = single, 1 = sawtooth repeat, 2 = triangle repeat, 3 = reserved (treated as 0).
- `f_start`  in  W  first frequency word (unsigned).
- `f_stop`  in  W  final frequency word (unsigned).
- `f_step`  in  W  step magnitude (unsigned, nonzero).
- `dwell`  in  DW  cycles per level; 0 is treated as 1.
- `freq`  out  W  frequency word to the DDS.
- `freq_upd`  out  1  one-cycle pulse on every cycle in which `freq` takes a new level.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a single-mode sweep completes.
- `err`  out  1  one-cycle pulse when a `start` is rejected.

## Operation
- Reset values: `freq`=0, `freq_upd`=0, `busy`=0, `done`=0, `err`=0, state IDLE, dwell counter 0.
- FSM states: IDLE, RUN, LAST.
- IDLE:
  - `start`=1 with `f_step`≠0: latch `mode`, `f_start`, `f_stop`, `f_step`, `dwell`. Set `freq`←`f_start`, pulse `freq_upd`, clear counter. Go to LAST if `f_start`=`f_stop`, else RUN.
  - `start`=1 with `f_step`=0: pulse `err` and stay in IDLE.
  - In IDLE, `freq` holds its last value.
- Direction: up if `f_stop`>`f_start`, down otherwise. It is fixed at latch time and toggled only by triangle mode.
- RUN:
  - Counter increments each cycle. When counter = D−1, where D = max(`dwell`,1), compute the next level.
  - Next level up: `freq`+`f_step`. Down: `freq`−`f_step`.
  - Compute in W+1 bits. If the result passes or equals the target (`f_stop` going up, `f_start` going down in triangle mode), clamp to the target and go to LAST.
  - Counter clears on every level change, and `freq_upd` pulses on every level change.
- LAST: hold the clamped endpoint for D cycles, then:
  - single: go to IDLE, drop `busy`, pulse `done` on the same edge; `freq` keeps the endpoint.
  - sawtooth: `freq`←`f_start`, pulse `freq_upd`, go to RUN.
  - triangle: reverse direction, take the first step away from the endpoint (`freq`∓`f_step`, clamped), go to RUN or LAST.
- Equal endpoints in repeat modes: hold `f_start` indefinitely; `freq_upd` pulses once per D cycles until abort.
- `abort`: any state goes to IDLE on the next edge. `freq` holds its current value; no `done`, no `freq_upd`.
- Precedence:
  - `abort` beats `start` in the same cycle.
  - `start` while busy is ignored (no `err`).
  - `rst` beats everything and may occur mid-sweep; outputs return to their reset values.
- Configuration inputs are sampled only on an accepted `start`. Changes during a sweep have no effect.

## Timing
- `start` sampled at edge k: `busy`=1, `freq`=`f_start` and `freq_upd`=1 are visible after edge k.
- Every level, including the first and last, is held exactly D cycles.
- Single sweep with N = ceil(|stop−start|/step)+1 levels:
  - `busy` is high for N·D cycles.
  - `done` and `busy` falling occur at edge k+N·D.
- `freq_upd` is coincident with the new `freq` value, so the DDS can use it as a load strobe.
- `abort` at edge j gives `busy`=0 after edge j.

## Structure
- Shared package `dds_pkg`:
  - `W` default constant;
  - mode encoding constants (`MODE_SINGLE`, `MODE_SAW`, `MODE_TRI`);
  - state enum (IDLE, RUN, LAST).
- Sub-module `dds_dwell_timer`: loadable DW-bit counter with clear and `expire` output (asserted at D−1, dwell 0 treated as 1).
- Top level: FSM, config latches, W+1-bit step/clamp arithmetic.

## Test plan
- Single up: start=100, stop=130, step=10, dwell=4 → `freq` 100/110/120/130, each for 4 cycles; four `freq_upd` pulses; `done` at edge +16.
- Single down with clamp: start=50, stop=5, step=20, dwell=1 → 50, 30, 10, 5; `done` at edge +4.
- Overflow: start=0xFFF0, stop=0xFFFF, step=0x20, dwell=2 → 0xFFF0 then 0xFFFF (no wrap to 0x0010); `done` at edge +4.
- Triangle: start=0, stop=20, step=10, dwell=1 → 0,10,20,10,0,10,20… continuing until abort; abort mid-level → `busy`=0 next edge, `freq` frozen, no `done`.
- Rejects/precedence: `f_step`=0 → `err` pulse, `busy` stays 0. start+abort in the same cycle → stays idle. start while busy → ignored.
- Reset mid-sweep in sawtooth mode → all outputs return to 0 on the next edge; a subsequent start behaves normally.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS frequency-sweep controller.
//   W_DEFAULT  default frequency word width (matches DDS freq port)
//   MODE_*     sweep mode encodings (3 is reserved and behaves as single)
//   state_t    sweep FSM states
package dds_pkg;

   localparam int W_DEFAULT = 16;

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_SAW    = 2'd1;
   localparam logic [1:0] MODE_TRI    = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: dwell counter for one frequency level.
//   clk, rst  clock and synchronous active-high reset
//   clr       clears the count to zero (level change or idle)
//   dwell     cycles per level; 0 behaves as 1
//   expire    high on the last cycle of the level (count = D-1)
module dds_dwell_timer #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [DW-1:0] dwell,
   output logic          expire
);

   logic [DW-1:0] cnt;

   // dwell of 0 or 1 means every cycle is the last one of its level
   assign expire = (dwell <= DW'(1)) || (cnt == dwell - DW'(1));

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else
         cnt <= cnt + DW'(1);
   end

endmodule

// File: rtl/dds_sweep.sv
// dds_sweep: staircase frequency sweep feeding the DDS freq input.
//   clk, rst                      clock, synchronous active-high reset
//   start, abort                  host control pulses
//   mode                          0 single, 1 sawtooth, 2 triangle, 3 = single
//   f_start, f_stop, f_step       sweep endpoints and step magnitude
//   dwell                         cycles per level (0 behaves as 1)
//   freq, freq_upd                frequency word and its load strobe
//   busy, done, err               sweep status
//
// state | meaning
// IDLE  | waiting for start; freq holds last value
// RUN   | stepping toward the current leg's target
// LAST  | holding a clamped endpoint for one dwell
module dds_sweep #(
   parameter int W  = dds_pkg::W_DEFAULT,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [1:0]    mode,
   input  logic [W-1:0]  f_start,
   input  logic [W-1:0]  f_stop,
   input  logic [W-1:0]  f_step,
   input  logic [DW-1:0] dwell,
   output logic [W-1:0]  freq,
   output logic          freq_upd,
   output logic          busy,
   output logic          done,
   output logic          err
);

   import dds_pkg::*;

   state_t        state;
   logic [1:0]    mode_q;
   logic [W-1:0]  fs_q, fe_q, st_q;
   logic [DW-1:0] dw_q;
   logic          dir_up;
   logic          ret;      // on the return leg of a triangle (target is f_start)
   logic          expire;
   logic          tmr_clr;
   logic [W-1:0]  tgt, tgt_rev;
   logic [W:0]    nxt_run, nxt_rev;

   // One step toward target in W+1 bits; bit W of the result flags a clamp.
   function automatic logic [W:0] step_clamp(input logic [W-1:0] cur,
                                             input logic [W-1:0] stp,
                                             input logic [W-1:0] target,
                                             input logic         up);
      logic [W:0] sum;
      logic [W:0] res;
      if (up) begin
         sum = {1'b0, cur} + {1'b0, stp};
         if (sum >= {1'b0, target})
            res = {1'b1, target};
         else
            res = {1'b0, sum[W-1:0]};
      end else begin
         sum = {1'b0, cur} - {1'b0, stp};
         // a borrow in bit W means the step went below zero
         if (sum[W] || (sum[W-1:0] <= target))
            res = {1'b1, target};
         else
            res = {1'b0, sum[W-1:0]};
      end
      return res;
   endfunction

   assign tgt     = ret ? fs_q : fe_q;
   assign tgt_rev = ret ? fe_q : fs_q;
   assign nxt_run = step_clamp(freq, st_q, tgt, dir_up);
   assign nxt_rev = step_clamp(freq, st_q, tgt_rev, !dir_up);
   assign tmr_clr = (state == IDLE) || expire || abort;

   dds_dwell_timer #(.DW(DW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .dwell  (dw_q),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         freq     <= '0;
         freq_upd <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         mode_q   <= MODE_SINGLE;
         fs_q     <= '0;
         fe_q     <= '0;
         st_q     <= '0;
         dw_q     <= '0;
         dir_up   <= 1'b0;
         ret      <= 1'b0;
      end else begin
         freq_upd <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (f_step == '0) begin
                        err <= 1'b1;
                     end else begin
                        mode_q   <= mode;
                        fs_q     <= f_start;
                        fe_q     <= f_stop;
                        st_q     <= f_step;
                        dw_q     <= dwell;
                        dir_up   <= (f_stop > f_start);
                        ret      <= 1'b0;
                        freq     <= f_start;
                        freq_upd <= 1'b1;
                        busy     <= 1'b1;
                        state    <= (f_start == f_stop) ? LAST : RUN;
                     end
                  end
               end
               RUN: begin
                  if (expire) begin
                     freq     <= nxt_run[W-1:0];
                     freq_upd <= 1'b1;
                     if (nxt_run[W])
                        state <= LAST;
                  end
               end
               LAST: begin
                  if (expire) begin
                     case (mode_q)
                        MODE_SAW: begin
                           freq     <= fs_q;
                           freq_upd <= 1'b1;
                           state    <= (fs_q == fe_q) ? LAST : RUN;
                        end
                        MODE_TRI: begin
                           dir_up   <= !dir_up;
                           ret      <= !ret;
                           freq     <= nxt_rev[W-1:0];
                           freq_upd <= 1'b1;
                           state    <= nxt_rev[W] ? LAST : RUN;
                        end
                        default: begin
                           state <= IDLE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     endcase
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dds_sweep.sv
module tb_dds_sweep;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [1:0]  mode;
   logic [15:0] f_start, f_stop, f_step, dwell;
   logic [15:0] freq;
   logic        freq_upd, busy, done, err;

   int errs   = 0;
   int checks = 0;

   dds_sweep #(.W(16), .DW(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .mode     (mode),
      .f_start  (f_start),
      .f_stop   (f_stop),
      .f_step   (f_step),
      .dwell    (dwell),
      .freq     (freq),
      .freq_upd (freq_upd),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]       mode;
      logic [15:0]      fs, fe, st, dw;
      int               n;
      logic [3:0][15:0] lv;   // lv[0] is the first level
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] m, input logic [15:0] fs, input logic [15:0] fe,
                      input logic [15:0] st, input logic [15:0] dw);
      mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
   endtask

   task automatic run_vector(input vec_t v, input int idx);
      int d, bad_f, bad_u, bad_b;
      d = (v.dw == 16'd0) ? 1 : int'(v.dw);
      bad_f = 0; bad_u = 0; bad_b = 0;
      cfg(v.mode, v.fs, v.fe, v.st, v.dw);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk($sformatf("v%0d first busy", idx), busy, 1);
      chk($sformatf("v%0d first freq", idx), freq, v.lv[0]);
      chk($sformatf("v%0d first upd", idx), freq_upd, 1);
      for (int i = 1; i < v.n * d; i++) begin
         tick;
         if (freq !== v.lv[i / d]) bad_f++;
         if (freq_upd !== ((i % d) == 0)) bad_u++;
         if (busy !== 1'b1 || done !== 1'b0) bad_b++;
      end
      chk($sformatf("v%0d freq trace errors", idx), bad_f, 0);
      chk($sformatf("v%0d upd trace errors", idx), bad_u, 0);
      chk($sformatf("v%0d busy trace errors", idx), bad_b, 0);
      tick;
      chk($sformatf("v%0d done at N*D", idx), done, 1);
      chk($sformatf("v%0d busy fall at N*D", idx), busy, 0);
      chk($sformatf("v%0d end freq", idx), freq, v.lv[v.n - 1]);
      chk($sformatf("v%0d no upd at end", idx), freq_upd, 0);
      tick;
      chk($sformatf("v%0d done one cycle", idx), done, 0);
   endtask

   initial begin
      int tri_exp[8];
      int saw_exp[6];
      int bad;

      vecs[0] = '{2'd0, 16'd100,   16'd130,   16'd10,   16'd4, 4,
                  {16'd130, 16'd120, 16'd110, 16'd100}};
      vecs[1] = '{2'd0, 16'd50,    16'd5,     16'd20,   16'd1, 4,
                  {16'd5, 16'd10, 16'd30, 16'd50}};
      vecs[2] = '{2'd0, 16'hFFF0,  16'hFFFF,  16'h0020, 16'd2, 2,
                  {16'd0, 16'd0, 16'hFFFF, 16'hFFF0}};
      vecs[3] = '{2'd0, 16'd7,     16'd9,     16'd1,    16'd0, 3,
                  {16'd0, 16'd9, 16'd8, 16'd7}};
      vecs[4] = '{2'd0, 16'd42,    16'd42,    16'd3,    16'd3, 1,
                  {16'd0, 16'd0, 16'd0, 16'd42}};
      vecs[5] = '{2'd3, 16'd10,    16'd0,     16'd4,    16'd2, 4,
                  {16'd0, 16'd2, 16'd6, 16'd10}};
      tri_exp = '{0, 10, 20, 10, 0, 10, 20, 10};
      saw_exp = '{0, 10, 20, 30, 0, 10};

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg(2'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      tick;
      tick;
      chk("reset freq", freq, 0);
      chk("reset upd", freq_upd, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      rst = 1'b0;
      tick;

      for (int k = 0; k < 6; k++)
         run_vector(vecs[k], k);

      // triangle trace, then abort
      cfg(2'd2, 16'd0, 16'd20, 16'd10, 16'd1);
      start = 1'b1;
      tick;
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick;
         if (freq !== 16'(tri_exp[i]) || freq_upd !== 1'b1 || busy !== 1'b1) bad++;
      end
      chk("tri trace errors", bad, 0);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("tri abort busy", busy, 0);
      chk("tri abort freq", freq, 10);
      chk("tri abort upd", freq_upd, 0);
      chk("tri abort done", done, 0);
      tick;
      chk("tri frozen freq", freq, 10);

      // zero step is rejected
      cfg(2'd0, 16'd1, 16'd9, 16'd0, 16'd1);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("zero step err", err, 1);
      chk("zero step busy", busy, 0);
      chk("zero step upd", freq_upd, 0);
      tick;
      chk("err one cycle", err, 0);

      // start while busy is ignored, config changes have no effect
      cfg(2'd0, 16'd100, 16'd130, 16'd10, 16'd4);
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      cfg(2'd1, 16'd0, 16'd500, 16'd0, 16'd1);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("busy start err", err, 0);
      chk("busy start freq", freq, 100);
      chk("busy start busy", busy, 1);
      tick;
      chk("busy start next level", freq, 110);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort busy", busy, 0);

      // start and abort together: abort wins
      cfg(2'd0, 16'd300, 16'd400, 16'd10, 16'd1);
      start = 1'b1; abort = 1'b1;
      tick;
      start = 1'b0; abort = 1'b0;
      chk("start+abort busy", busy, 0);
      chk("start+abort upd", freq_upd, 0);
      chk("start+abort freq", freq, 110);
      chk("start+abort err", err, 0);

      // sawtooth with equal endpoints: hold and strobe every D cycles
      cfg(2'd1, 16'd5, 16'd5, 16'd1, 16'd2);
      start = 1'b1;
      tick;
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) tick;
         if (freq !== 16'd5 || busy !== 1'b1 || freq_upd !== ((i % 2) == 0)) bad++;
      end
      chk("saw equal trace errors", bad, 0);
      abort = 1'b1;
      tick;
      abort = 1'b0;

      // sawtooth wrap, then reset mid-sweep
      cfg(2'd1, 16'd0, 16'd30, 16'd10, 16'd1);
      start = 1'b1;
      tick;
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick;
         if (freq !== 16'(saw_exp[i]) || freq_upd !== 1'b1 || busy !== 1'b1) bad++;
      end
      chk("saw trace errors", bad, 0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mid reset freq", freq, 0);
      chk("mid reset busy", busy, 0);
      chk("mid reset upd", freq_upd, 0);
      chk("mid reset done", done, 0);
      tick;
      run_vector(vecs[0], 10);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
